// File: rtl/hist_pkg.sv
// Shared types and sizes for the histogram-equalization frame sequencer.
//   state_e   : sequencer phase
//   bin_req_t : {valid, bin address} payload carried down the update delay line
package hist_pkg;

    localparam int unsigned BINS   = 256;
    localparam int unsigned BIN_AW = 8;

    typedef enum logic [2:0] {
        CLEAR,
        SYNC,
        COLLECT,
        LOAD,
        DRAIN
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [BIN_AW-1:0] addr;
    } bin_req_t;

endpackage

// File: rtl/hist_dly_line.sv
// Fixed-depth shift register for bin requests (valid + address).
//   clk, rst_n : clock, asynchronous active-low reset (flushes all stages)
//   din        : request entering the line
//   pre        : request that will appear on dout after the next edge
//   dout       : din delayed by DEPTH cycles
module hist_dly_line
    import hist_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic     clk,
    input  logic     rst_n,
    input  bin_req_t din,
    output bin_req_t pre,
    output bin_req_t dout
);

    bin_req_t stage [DEPTH];

    // Shift stages; reset drops every in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    // Look-ahead tap lets the consumer register a flag that lines up with dout.
    generate
        if (DEPTH == 1) begin : g_pre_in
            assign pre = din;
        end else begin : g_pre_stage
            assign pre = stage[DEPTH-2];
        end
    endgenerate

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/hist_seq_ctrl.sv
// Frame-phase sequencer for the histogram-equalization pipeline.
// Schedules bin clearing, pixel collection, bin read-out to the CDF unit and
// the delayed LUT update strobes, and resynchronises when pixels arrive while
// the histogram is busy.
//   clk, rst             : clock, asynchronous active-low reset
//   sink_valid, sink_eop : video pixel strobe and end-of-frame marker
//   collect_en           : collector may count the current pixel (state decode)
//   data_load(_addr)     : bin read strobe/address to the CDF unit
//   update(_addr)        : LUT write strobe/address, data_load delayed PIPE_LAT
//   clean(_addr)         : bin clear strobe/address to the collector
//   lut_valid            : a full LUT has been written since reset
//   frame_drop           : pulse, a frame is being skipped to resync
//   size_err             : pulse, collected frame size differed from TOTOLNUM
module hist_seq_ctrl
    import hist_pkg::*;
#(
    parameter int unsigned PIPE_LAT = 3,
    parameter int unsigned TOTOLNUM = 1920*1080/4,
    parameter int unsigned CNTW     = $clog2(TOTOLNUM+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sink_valid,
    input  logic              sink_eop,
    output logic              collect_en,
    output logic              data_load,
    output logic [BIN_AW-1:0] data_load_addr,
    output logic              update,
    output logic [BIN_AW-1:0] update_addr,
    output logic              clean,
    output logic [BIN_AW-1:0] clean_addr,
    output logic              lut_valid,
    output logic              frame_drop,
    output logic              size_err
);

    localparam logic [BIN_AW-1:0] LAST_BIN   = BIN_AW'(BINS-1);
    localparam logic [BIN_AW-1:0] DRAIN_LAST = BIN_AW'(PIPE_LAT-1);
    localparam logic [CNTW-1:0]   FRAME_PIX  = CNTW'(TOTOLNUM);

    state_e            state, state_nxt;
    logic [BIN_AW-1:0] bin, bin_nxt;
    logic [CNTW-1:0]   pix_cnt, pix_cnt_nxt, pix_inc;
    logic              missed, missed_nxt;
    logic              size_err_nxt;
    logic              frame_drop_nxt;
    logic              eop_in;
    bin_req_t          load_req, upd_pre, upd_req;

    assign eop_in  = sink_valid & sink_eop;
    assign pix_inc = (pix_cnt == '1) ? pix_cnt : pix_cnt + 1'b1;

    // Collection gate follows the phase directly so the eop pixel is counted.
    assign collect_en = (state == COLLECT);

    // Next-state, shared bin counter, pixel counter and resync flag.
    always_comb begin
        state_nxt      = state;
        bin_nxt        = bin;
        pix_cnt_nxt    = pix_cnt;
        missed_nxt     = missed;
        size_err_nxt   = 1'b0;
        frame_drop_nxt = 1'b0;

        case (state)
            CLEAR: begin
                if (sink_valid) begin
                    missed_nxt = 1'b1;
                end
                // Counter only advances once a clean strobe is actually out,
                // so the first cycle after reset release is not lost.
                if (clean) begin
                    if (bin == LAST_BIN) begin
                        bin_nxt    = '0;
                        missed_nxt = 1'b0;
                        if (missed || sink_valid) begin
                            state_nxt      = SYNC;
                            frame_drop_nxt = 1'b1;
                        end else begin
                            state_nxt = COLLECT;
                        end
                    end else begin
                        bin_nxt = bin + 1'b1;
                    end
                end
            end
            SYNC: begin
                if (eop_in) begin
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (sink_valid) begin
                    if (sink_eop) begin
                        size_err_nxt = (pix_inc != FRAME_PIX);
                        pix_cnt_nxt  = '0;
                        state_nxt    = LOAD;
                    end else begin
                        pix_cnt_nxt = pix_inc;
                    end
                end
            end
            LOAD: begin
                if (sink_valid) begin
                    missed_nxt = 1'b1;
                end
                if (bin == LAST_BIN) begin
                    bin_nxt   = '0;
                    state_nxt = DRAIN;
                end else begin
                    bin_nxt = bin + 1'b1;
                end
            end
            DRAIN: begin
                if (sink_valid) begin
                    missed_nxt = 1'b1;
                end
                if (bin == DRAIN_LAST) begin
                    bin_nxt   = '0;
                    state_nxt = CLEAR;
                end else begin
                    bin_nxt = bin + 1'b1;
                end
            end
            default: begin
                state_nxt = CLEAR;
                bin_nxt   = '0;
            end
        endcase
    end

    // State, counters and registered strobes aligned with the phase they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= CLEAR;
            bin            <= '0;
            pix_cnt        <= '0;
            missed         <= 1'b0;
            size_err       <= 1'b0;
            frame_drop     <= 1'b0;
            clean          <= 1'b0;
            clean_addr     <= '0;
            data_load      <= 1'b0;
            data_load_addr <= '0;
            lut_valid      <= 1'b0;
        end else begin
            state          <= state_nxt;
            bin            <= bin_nxt;
            pix_cnt        <= pix_cnt_nxt;
            missed         <= missed_nxt;
            size_err       <= size_err_nxt;
            frame_drop     <= frame_drop_nxt;
            clean          <= (state_nxt == CLEAR);
            clean_addr     <= (state_nxt == CLEAR) ? bin_nxt : '0;
            data_load      <= (state_nxt == LOAD);
            data_load_addr <= (state_nxt == LOAD) ? bin_nxt : '0;
            lut_valid      <= lut_valid | (upd_pre.valid & (upd_pre.addr == LAST_BIN));
        end
    end

    assign load_req.valid = data_load;
    assign load_req.addr  = data_load_addr;

    hist_dly_line #(
        .DEPTH (PIPE_LAT)
    ) u_upd_dly (
        .clk   (clk),
        .rst_n (rst),
        .din   (load_req),
        .pre   (upd_pre),
        .dout  (upd_req)
    );

    assign update      = upd_req.valid;
    assign update_addr = upd_req.addr;

endmodule

// File: tb/tb_hist_seq_ctrl.sv
// Directed bench for hist_seq_ctrl (PIPE_LAT=3). Two instances share stimulus:
// one expects 8-pixel frames, the other 9, to exercise the size check.
module tb_hist_seq_ctrl;

    localparam int PL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sink_valid = 1'b0;
    logic sink_eop = 1'b0;

    logic       collect_en, data_load, update, clean, lut_valid, frame_drop, size_err;
    logic [7:0] data_load_addr, update_addr, clean_addr;

    logic       b_collect_en, b_data_load, b_update, b_clean, b_lut_valid, b_frame_drop, b_size_err;
    logic [7:0] b_data_load_addr, b_update_addr, b_clean_addr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hist_seq_ctrl #(.PIPE_LAT(PL), .TOTOLNUM(8)) dut (
        .clk(clk), .rst(rst), .sink_valid(sink_valid), .sink_eop(sink_eop),
        .collect_en(collect_en), .data_load(data_load), .data_load_addr(data_load_addr),
        .update(update), .update_addr(update_addr), .clean(clean), .clean_addr(clean_addr),
        .lut_valid(lut_valid), .frame_drop(frame_drop), .size_err(size_err)
    );

    hist_seq_ctrl #(.PIPE_LAT(PL), .TOTOLNUM(9)) dut9 (
        .clk(clk), .rst(rst), .sink_valid(sink_valid), .sink_eop(sink_eop),
        .collect_en(b_collect_en), .data_load(b_data_load), .data_load_addr(b_data_load_addr),
        .update(b_update), .update_addr(b_update_addr), .clean(b_clean), .clean_addr(b_clean_addr),
        .lut_valid(b_lut_valid), .frame_drop(b_frame_drop), .size_err(b_size_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({collect_en, data_load, data_load_addr, update, update_addr,
                    clean, clean_addr, lut_valid, frame_drop, size_err});
    endfunction

    // Wait (bounded) for the clear phase, then check 256 strobes and the COLLECT entry.
    task automatic clear_run(input string tag);
        for (int i = 0; i < 8; i++) begin
            if (clean) break;
            step();
        end
        chk({tag, "_start"}, 32'(clean), 32'd1);
        for (int i = 0; i < 256; i++) begin
            chk({tag, "_seq"}, 32'({clean, clean_addr, update, frame_drop, collect_en, data_load}),
                32'({1'b1, 8'(i), 4'b0000}));
            step();
        end
        chk({tag, "_done"}, 32'({clean, collect_en, frame_drop}), 32'b010);
    endtask

    // Drive n pixels with eop on the last; returns in the eop cycle T.
    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) begin
            chk("collect_gate", 32'(collect_en), 32'd1);
            sink_valid = 1'b1;
            sink_eop   = (i == n - 1);
            if (i < n - 1) step();
        end
    endtask

    // Walk cycles T+1..T+513+PL after an accepted eop against the frame schedule.
    task automatic frame_window(input int drop_at, input bit lut_before);
        logic       e_dl, e_up, e_cl, e_ce, e_fd, e_lv;
        logic [7:0] e_dla, e_upa, e_cla;
        for (int k = 1; k <= 513 + PL; k++) begin
            step();
            e_dl  = (k >= 1) && (k <= 256);
            e_dla = e_dl ? 8'(k - 1) : 8'd0;
            e_up  = (k >= 1 + PL) && (k <= 256 + PL);
            e_upa = e_up ? 8'(k - 1 - PL) : 8'd0;
            e_cl  = (k >= 257 + PL) && (k <= 512 + PL);
            e_cla = e_cl ? 8'(k - 257 - PL) : 8'd0;
            e_ce  = (k == 513 + PL) && (drop_at == 0);
            e_fd  = (k == 513 + PL) && (drop_at != 0);
            e_lv  = lut_before || (k >= 256 + PL);
            chk("load", 32'({data_load, data_load_addr}), 32'({e_dl, e_dla}));
            chk("update", 32'({update, update_addr}), 32'({e_up, e_upa}));
            chk("clean", 32'({clean, clean_addr}), 32'({e_cl, e_cla}));
            chk("flags", 32'({collect_en, frame_drop, lut_valid, size_err, b_size_err}),
                32'({e_ce, e_fd, e_lv, 1'b0, (k == 1)}));
            sink_valid = (k == drop_at);
            sink_eop   = 1'b0;
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) step();
        chk("reset_outs", all_outs(), 32'd0);
        rst = 1'b1;
        clear_run("init_clr");

        // eop without valid must not end collection
        sink_eop = 1'b1;
        repeat (5) begin
            step();
            chk("eop_novalid", 32'({collect_en, data_load, size_err}), 32'b100);
        end
        sink_eop = 1'b0;

        // normal frame
        send_frame(8);
        frame_window(0, 1'b0);

        // frame with a stray pixel during LOAD -> resync
        send_frame(8);
        frame_window(100, 1'b1);

        // in SYNC: a plain pixel is ignored, eop re-arms collection
        sink_valid = 1'b1;
        sink_eop   = 1'b0;
        step();
        chk("sync_hold", 32'({collect_en, frame_drop}), 32'b00);
        sink_eop = 1'b1;
        step();
        chk("sync_exit", 32'({collect_en, frame_drop}), 32'b10);
        sink_valid = 1'b0;
        sink_eop   = 1'b0;

        // next frame starts loading, then reset mid-LOAD
        send_frame(8);
        for (int k = 1; k <= 5; k++) begin
            step();
            sink_valid = 1'b0;
            sink_eop   = 1'b0;
            chk("load2", 32'({data_load, data_load_addr, lut_valid, size_err}),
                32'({1'b1, 8'(k - 1), 1'b1, 1'b0}));
        end
        rst = 1'b0;
        #1;
        chk("midload_rst", all_outs(), 32'd0);
        step();
        chk("midload_rst_hold", all_outs(), 32'd0);
        rst = 1'b1;
        clear_run("post_rst_clr");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
